// File: rtl/noc_axis_pkg.sv
// Shared AXI-Stream definitions for the port FIFO array.
// Contents:
//   payload_width() - bits needed to hold one stored beat {tdest,tid,tlast,tdata}
//   axis_beat_t     - packed beat layout at the default widths (32/2/4)
package noc_axis_pkg;

    localparam int DEF_TDATA_WIDTH = 32;
    localparam int DEF_TID_WIDTH   = 2;
    localparam int DEF_TDEST_WIDTH = 4;

    // One stored beat: data, id, dest and the single tlast bit.
    function automatic int payload_width(input int tdata_w, input int tid_w, input int tdest_w);
        return tdata_w + tid_w + tdest_w + 1;
    endfunction

    // Field order matches the flat storage word: tdata in the low bits,
    // tlast directly above it, then tid, then tdest.
    typedef struct packed {
        logic [DEF_TDEST_WIDTH-1:0] tdest;
        logic [DEF_TID_WIDTH-1:0]   tid;
        logic                       tlast;
        logic [DEF_TDATA_WIDTH-1:0] tdata;
    } axis_beat_t;

endpackage

// File: rtl/axis_port_fifo_array_if.sv
// Bundle of NUM_PORTS AXI-Stream channels carried as flat vectors
// (channel i occupies slice i of every bus).
// Handshake: a beat moves on a rising clk_usr edge where tvalid[i] and
// tready[i] are both 1; once tvalid[i] is raised the payload stays stable
// until that transfer happens.
// Modports:
//   master - drives tvalid/tdata/tlast/tid/tdest, receives tready
//   slave  - receives tvalid/tdata/tlast/tid/tdest, drives tready
interface axis_port_fifo_array_if #(
    parameter int NUM_PORTS   = 5,
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4
);
    logic [NUM_PORTS-1:0]             tvalid;
    logic [NUM_PORTS-1:0]             tready;
    logic [NUM_PORTS-1:0]             tlast;
    logic [NUM_PORTS*TDATA_WIDTH-1:0] tdata;
    logic [NUM_PORTS*TID_WIDTH-1:0]   tid;
    logic [NUM_PORTS*TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_fifo_chan.sv
// One AXI-Stream FIFO channel, first-word fall-through, one cycle latency.
// Ports:
//   clk_usr, rst_n      - clock, asynchronous active-low reset
//   s_valid/s_ready     - input handshake; s_ready is registered
//   s_beat              - input payload {tdest,tid,tlast,tdata}
//   m_valid/m_ready     - output handshake; m_valid = (occupancy != 0)
//   m_beat              - head entry
//   flush               - synchronous discard of the whole channel
//   occupancy           - stored entry count, 0..DEPTH
//   pkt_count           - wrapping count of output beats carrying tlast
module axis_fifo_chan
    import noc_axis_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 16,
    localparam int PW         = payload_width(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH),
    localparam int AW         = $clog2(DEPTH),
    localparam int OW         = $clog2(DEPTH) + 1
) (
    input  logic                 clk_usr,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PW-1:0]        s_beat,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PW-1:0]        m_beat,
    input  logic                 flush,
    output logic [OW-1:0]        occupancy,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ_next;
    logic          wr_en;
    logic          rd_en;

    // A flush cycle swallows both sides of the handshake.
    assign wr_en   = s_valid && s_ready && !flush;
    assign rd_en   = m_valid && m_ready && !flush;
    assign m_valid = (occupancy != '0);
    assign m_beat  = mem[rd_ptr];

    always_comb begin
        occ_next = occupancy + OW'(wr_en) - OW'(rd_en);
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            s_ready   <= 1'b0;
            pkt_count <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            s_ready   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            occupancy <= occ_next;
            // Registered ready: a read while full frees the slot only for
            // the next cycle, never for a same-cycle write.
            s_ready   <= (occ_next < OW'(DEPTH));
            if (rd_en && m_beat[TDATA_WIDTH]) pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_usr) begin
        if (wr_en) mem[wr_ptr] <= s_beat;
    end
endmodule

// File: rtl/axis_port_fifo_array.sv
// Array of NUM_PORTS independent AXI-Stream FIFOs.
// Ports:
//   clk_usr, rst_n - clock, asynchronous active-low reset
//   s_axis         - slave side bundle (input streams)
//   m_axis         - master side bundle (output streams)
//   flush          - per-channel synchronous discard
//   occupancy      - per-channel entry count, ($clog2(DEPTH)+1) bits each
//   pkt_count      - per-channel tlast beat count, CNT_WIDTH bits each
module axis_port_fifo_array
    import noc_axis_pkg::*;
#(
    parameter int NUM_PORTS   = 5,
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                     clk_usr,
    input  logic                                     rst_n,
    axis_port_fifo_array_if.slave                    s_axis,
    axis_port_fifo_array_if.master                   m_axis,
    input  logic [NUM_PORTS-1:0]                     flush,
    output logic [NUM_PORTS*($clog2(DEPTH)+1)-1:0]   occupancy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]           pkt_count
);
    localparam int PW = payload_width(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH);
    localparam int OW = $clog2(DEPTH) + 1;

    logic [NUM_PORTS-1:0] s_ready_v;
    logic [NUM_PORTS-1:0] m_valid_v;
    logic [PW-1:0]        m_beat_v [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
        logic [PW-1:0] s_beat;

        assign s_beat = {s_axis.tdest[i*TDEST_WIDTH +: TDEST_WIDTH],
                         s_axis.tid[i*TID_WIDTH +: TID_WIDTH],
                         s_axis.tlast[i],
                         s_axis.tdata[i*TDATA_WIDTH +: TDATA_WIDTH]};

        axis_fifo_chan #(
            .TDATA_WIDTH (TDATA_WIDTH),
            .TID_WIDTH   (TID_WIDTH),
            .TDEST_WIDTH (TDEST_WIDTH),
            .DEPTH       (DEPTH),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_chan (
            .clk_usr   (clk_usr),
            .rst_n     (rst_n),
            .s_valid   (s_axis.tvalid[i]),
            .s_ready   (s_ready_v[i]),
            .s_beat    (s_beat),
            .m_valid   (m_valid_v[i]),
            .m_ready   (m_axis.tready[i]),
            .m_beat    (m_beat_v[i]),
            .flush     (flush[i]),
            .occupancy (occupancy[i*OW +: OW]),
            .pkt_count (pkt_count[i*CNT_WIDTH +: CNT_WIDTH])
        );

        assign m_axis.tdata[i*TDATA_WIDTH +: TDATA_WIDTH] = m_beat_v[i][TDATA_WIDTH-1:0];
        assign m_axis.tlast[i]                            = m_beat_v[i][TDATA_WIDTH];
        assign m_axis.tid[i*TID_WIDTH +: TID_WIDTH]       = m_beat_v[i][TDATA_WIDTH+1 +: TID_WIDTH];
        assign m_axis.tdest[i*TDEST_WIDTH +: TDEST_WIDTH] = m_beat_v[i][TDATA_WIDTH+1+TID_WIDTH +: TDEST_WIDTH];
    end

    assign s_axis.tready = s_ready_v;
    assign m_axis.tvalid = m_valid_v;
endmodule

// File: doc/axis_port_fifo_array.md
AXIS_PORT_FIFO_ARRAY -- requirements
Module: axis_port_fifo_array

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, meaning number of independent AXIS channels.
REQ-002 SHALL have parameter TDATA_WIDTH, default 32, meaning data bits per beat.
REQ-003 SHALL have parameter TID_WIDTH, default 2, meaning TID bits.
REQ-004 SHALL have parameter TDEST_WIDTH, default 4, meaning TDEST bits.
REQ-005 SHALL have parameter DEPTH, default 4, meaning entries per channel FIFO; power of 2, at least 2.
REQ-006 SHALL have parameter CNT_WIDTH, default 16, meaning per-channel packet counter width.
REQ-007 clk_usr  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 s_axis_tvalid  in  NUM_PORTS  per-channel input valid.
REQ-010 s_axis_tready  out  NUM_PORTS  per-channel input ready.
REQ-011 s_axis_tdata  in  NUM_PORTS*TDATA_WIDTH  flat input data, channel i at slice i.
REQ-012 s_axis_tlast / s_axis_tid / s_axis_tdest  in  NUM_PORTS, NUM_PORTS*TID_WIDTH, NUM_PORTS*TDEST_WIDTH  input sidebands.
REQ-013 m_axis_tvalid  out  NUM_PORTS  per-channel output valid.
REQ-014 m_axis_tready  in  NUM_PORTS  per-channel output ready.
REQ-015 m_axis_tdata / tlast / tid / tdest  out  same widths as inputs  output beat.
REQ-016 flush  in  NUM_PORTS  synchronous per-channel discard request.
REQ-017 occupancy  out  NUM_PORTS*($clog2(DEPTH)+1)  per-channel entry count.
REQ-018 pkt_count  out  NUM_PORTS*CNT_WIDTH  per-channel count of output beats with tlast.

Function
REQ-019 Each channel SHALL be an independent FIFO; no cross-channel interaction.
REQ-020 Input beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both 1 at a clock edge; {tdest,tid,tlast,tdata} stored together.
REQ-021 Output beat SHALL transfer when m_axis_tvalid and m_axis_tready are both 1; head entry then retired.
REQ-022 m_axis_tvalid SHALL equal (occupancy != 0); output payload SHALL be the head entry (first-word fall-through).
REQ-023 Latency SHALL be 1 cycle: beat accepted at edge k is valid on output after edge k when the FIFO was empty.
REQ-024 s_axis_tready SHALL be registered: after each edge equals (occupancy_next < DEPTH) and not flushing.
REQ-025 Full (occupancy == DEPTH): s_axis_tready 0; a simultaneous output transfer re-raises tready next cycle; no write bypass.
REQ-026 Empty: m_axis_tvalid 0; output payload don't-care; no read bypass of an incoming beat.
REQ-027 Simultaneous accept and transfer SHALL leave occupancy unchanged and advance both pointers.
REQ-028 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH nor underflow.
REQ-029 Once m_axis_tvalid is 1, payload SHALL stay stable until transfer (AXIS rule); upstream holding requirement likewise assumed of source.
REQ-030 flush[i]=1 at an edge SHALL zero channel i pointers and occupancy, discard any beat offered that cycle, ignore output transfer, force s_axis_tready[i]=0 for that cycle; pkt_count[i] unchanged.
REQ-031 pkt_count SHALL increment on each output transfer with tlast=1, wrapping 2^CNT_WIDTH-1 -> 0.

Reset
REQ-032 While rst_n=0: all pointers, occupancy, pkt_count SHALL be 0; s_axis_tready 0; m_axis_tvalid 0.
REQ-033 First edge after rst_n release SHALL set s_axis_tready to all 1s; no beat accepted at that edge.
REQ-034 Reset asserted mid-transfer SHALL discard all stored beats immediately, asynchronously.
REQ-035 Storage array contents SHALL need no reset.

Structure
REQ-036 Shared package noc_axis_pkg SHALL hold the payload-width function (TDATA+TID+TDEST+1) and the packed beat typedef.
REQ-037 One sub-module axis_fifo_chan SHALL implement one channel; top generates NUM_PORTS instances and slices flat buses.

Verification
REQ-038 Reset release, port 0 sends 0xDEADBEEF tlast=1 tdest=3 -> m_axis_tvalid[0] 1 cycle later with same payload; pkt_count[0]=1 after transfer.
REQ-039 Port 2 m_axis_tready=0, send 5 beats with DEPTH=4 -> 4 accepted, occupancy[2]=4, s_axis_tready[2]=0; release ready -> beats 0..3 in order, 5th accepted.
REQ-040 Full FIFO, simultaneous transfer and offered beat -> beat not accepted that cycle, tready 1 next cycle, occupancy 3 then 4.
REQ-041 Occupancy 3 on port 1, flush[1] pulse with valid beat offered -> occupancy 0, m_axis_tvalid[1] 0, offered beat lost, other ports unaffected.
REQ-042 CNT_WIDTH=4, 17 tlast beats on port 4 -> pkt_count[4]=1.
REQ-043 All 5 ports streaming random data, random ready back-pressure, rst_n pulsed mid-stream -> per-port order preserved before reset, all outputs 0 during reset.
